// File: rtl/dpram_pkg.sv
// Shared types and helpers for the byte-enabled dual-port RAM and its clear sequencer.
// Helpers work on words of up to MAX_BYTES bytes; callers size-cast at the call site.
package dpram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam int RDW_OLD   = 0;
    localparam int RDW_NEW   = 1;
    localparam int MAX_BYTES = 8;
    localparam int MAX_W     = 8 * MAX_BYTES;

    // New bytes where be is set, old bytes elsewhere.
    function automatic logic [MAX_W-1:0] byte_merge(
        input logic [MAX_W-1:0]     old_w,
        input logic [MAX_W-1:0]     new_w,
        input logic [MAX_BYTES-1:0] be
    );
        logic [MAX_W-1:0] r;
        r = old_w;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (be[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
        end
        return r;
    endfunction

    function automatic logic [MAX_BYTES-1:0] par_bytes(input logic [MAX_W-1:0] word);
        logic [MAX_BYTES-1:0] p;
        for (int i = 0; i < MAX_BYTES; i++) begin
            p[i] = ^word[i*8 +: 8];
        end
        return p;
    endfunction

endpackage

// File: rtl/dpram_be_clr_if.sv
// Bus bundle for dpram_be_clr: clear control, both access ports, collision and parity flags.
// par_flip_a exists only when DPRAM_PARITY_EN is defined.
interface dpram_be_clr_if #(
    parameter int BYTES  = 1,
    parameter int ADDR_W = 10
) ();
    localparam int W = 8 * BYTES;

    logic              clear_req;
    logic              busy;
    logic              ce_a,      ce_b;
    logic              wren_a,    wren_b;
    logic [BYTES-1:0]  byteena_a, byteena_b;
    logic [ADDR_W-1:0] address_a, address_b;
    logic [W-1:0]      data_a,    data_b;
    logic [W-1:0]      q_a,       q_b;
    logic              valid_a,   valid_b;
    logic              collision;
    logic              perr_a,    perr_b;
`ifdef DPRAM_PARITY_EN
    logic              par_flip_a;
`endif

    modport master (
        output clear_req, ce_a, wren_a, byteena_a, address_a, data_a,
               ce_b, wren_b, byteena_b, address_b, data_b,
        input  busy, q_a, valid_a, q_b, valid_b, collision, perr_a, perr_b
`ifdef DPRAM_PARITY_EN
        , output par_flip_a
`endif
    );

    modport slave (
        input  clear_req, ce_a, wren_a, byteena_a, address_a, data_a,
               ce_b, wren_b, byteena_b, address_b, data_b,
        output busy, q_a, valid_a, q_b, valid_b, collision, perr_a, perr_b
`ifdef DPRAM_PARITY_EN
        , input par_flip_a
`endif
    );

endinterface

// File: rtl/dpram_clr_seq.sv
// Clear sequencer: walks every word address once after reset or a clear request,
// then hands the RAM over to the access ports.
module dpram_clr_seq
    import dpram_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_clear_req,
    output logic              o_busy,
    output logic              o_clr_we,
    output logic [ADDR_W-1:0] o_clr_addr
);

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_addr,  w_addr_nxt;

    // NOTE: sequential state uses non-blocking assignments only; next-state logic lives in always_comb.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= CLEAR;
            r_addr  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
        end
    end

    // NOTE: defaults first so no path through the case leaves a latch behind.
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        case (r_state)
            CLEAR: begin
                w_addr_nxt = r_addr + ADDR_W'(1);
                if (r_addr == '1) w_state_nxt = RUN;
            end
            RUN: begin
                if (i_clear_req) begin
                    w_state_nxt = CLEAR;
                    w_addr_nxt  = '0;
                end
            end
            default: w_state_nxt = CLEAR;
        endcase
    end

    assign o_busy     = (r_state == CLEAR);
    assign o_clr_we   = (r_state == CLEAR);
    assign o_clr_addr = r_addr;

endmodule

// File: rtl/dpram_be_clr.sv
// Single-clock true dual-port RAM with byte enables, selectable read-during-write,
// optional output register and hardware clear. Optional per-byte parity: DPRAM_PARITY_EN.
module dpram_be_clr
    import dpram_pkg::*;
#(
    parameter int          BYTES     = 1,
    parameter int          ADDR_W    = 10,
    parameter int          RDW_MODE  = RDW_OLD,
    parameter int          OUT_REG   = 0,
    parameter logic [7:0]  CLEAR_VAL = 8'h00
) (
    input  logic           clock,
    input  logic           reset,
    dpram_be_clr_if.slave  bus
);
    localparam int W = 8 * BYTES;
    localparam int D = 2 ** ADDR_W;

    logic              w_busy;
    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_addr;

    dpram_clr_seq #(.ADDR_W(ADDR_W)) u_clr_seq (
        .i_clock     (clock),
        .i_reset     (reset),
        .i_clear_req (bus.clear_req),
        .o_busy      (w_busy),
        .o_clr_we    (w_clr_we),
        .o_clr_addr  (w_clr_addr)
    );

    // Index 0 is port A, index 1 is port B.
    logic [1:0]              w_acc, w_we, w_perr_any;
    logic [1:0][ADDR_W-1:0]  w_addr;
    logic [1:0][BYTES-1:0]   w_be;
    logic [1:0][W-1:0]       w_din, w_old, w_rd;

    assign w_acc     = {bus.ce_b, bus.ce_a} & {2{~w_busy}};
    assign w_we      = w_acc & {bus.wren_b, bus.wren_a};
    assign w_addr    = {bus.address_b, bus.address_a};
    assign w_din     = {bus.data_b, bus.data_a};
    assign w_be[0]   = w_we[0] ? bus.byteena_a : '0;
    assign w_be[1]   = w_we[1] ? bus.byteena_b : '0;

    // NOTE: the array has no reset; the clear sequencer gives it a known state instead.
    logic [W-1:0] r_mem [D];

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_old[p] = r_mem[w_addr[p]];
            w_rd[p]  = w_old[p];
            if (RDW_MODE == RDW_NEW && w_we[p])
                w_rd[p] = W'(byte_merge(MAX_W'(w_old[p]), MAX_W'(w_din[p]), MAX_BYTES'(w_be[p])));
        end
    end

    // Port B is applied first so port A wins on overlapping enabled bytes.
    always_ff @(posedge clock) begin
        if (w_clr_we) begin
            r_mem[w_clr_addr] <= {BYTES{CLEAR_VAL}};
        end else begin
            for (int i = 0; i < BYTES; i++) begin
                if (w_be[1][i]) r_mem[w_addr[1]][i*8 +: 8] <= w_din[1][i*8 +: 8];
                if (w_be[0][i]) r_mem[w_addr[0]][i*8 +: 8] <= w_din[0][i*8 +: 8];
            end
        end
    end

`ifdef DPRAM_PARITY_EN
    logic [BYTES-1:0]      r_par [D];
    logic [1:0][BYTES-1:0] w_par_new;

    assign w_par_new[0] = BYTES'(par_bytes(MAX_W'(w_din[0]))) ^ {BYTES{bus.par_flip_a}};
    assign w_par_new[1] = BYTES'(par_bytes(MAX_W'(w_din[1])));

    always_ff @(posedge clock) begin
        if (w_clr_we) begin
            r_par[w_clr_addr] <= {BYTES{^CLEAR_VAL}};
        end else begin
            for (int i = 0; i < BYTES; i++) begin
                if (w_be[1][i]) r_par[w_addr[1]][i] <= w_par_new[1][i];
                if (w_be[0][i]) r_par[w_addr[0]][i] <= w_par_new[0][i];
            end
        end
    end

    // Parity is checked on the stored word being read, before any same-cycle write lands.
    always_comb begin
        for (int p = 0; p < 2; p++)
            w_perr_any[p] = |(BYTES'(par_bytes(MAX_W'(w_old[p]))) ^ r_par[w_addr[p]]);
    end
`else
    assign w_perr_any = '0;
`endif

    logic [1:0][W-1:0] r_q1;
    logic [1:0]        r_v1, r_pe1;
    logic              r_coll;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_q1   <= '0;
            r_v1   <= '0;
            r_pe1  <= '0;
            r_coll <= 1'b0;
        end else begin
            r_v1   <= w_acc;
            r_pe1  <= w_acc & w_perr_any;
            r_coll <= (&w_we) && (w_addr[0] == w_addr[1]) && (|w_be[0]) && (|w_be[1]);
            for (int p = 0; p < 2; p++) begin
                if (w_acc[p]) r_q1[p] <= w_rd[p];
            end
        end
    end

    logic [1:0][W-1:0] w_q;
    logic [1:0]        w_v, w_pe, w_valid;

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [1:0][W-1:0] r_q2;
            logic [1:0]        r_v2, r_pe2;
            always_ff @(posedge clock) begin
                if (reset) begin
                    r_q2  <= '0;
                    r_v2  <= '0;
                    r_pe2 <= '0;
                end else begin
                    r_q2  <= r_q1;
                    r_v2  <= r_v1;
                    r_pe2 <= r_pe1;
                end
            end
            assign w_q  = r_q2;
            assign w_v  = r_v2;
            assign w_pe = r_pe2;
        end else begin : g_noreg
            assign w_q  = r_q1;
            assign w_v  = r_v1;
            assign w_pe = r_pe1;
        end
    endgenerate

    assign w_valid       = w_v & {2{~w_busy}};
    assign bus.busy      = w_busy;
    assign bus.q_a       = w_q[0];
    assign bus.q_b       = w_q[1];
    assign bus.valid_a   = w_valid[0];
    assign bus.valid_b   = w_valid[1];
    assign bus.perr_a    = w_pe[0] & w_valid[0];
    assign bus.perr_b    = w_pe[1] & w_valid[1];
    assign bus.collision = r_coll;

endmodule
